// File: rtl/interrupt_acceptor.sv
// rtl/interrupt_acceptor.sv - CPU-side interrupt acceptor running the MSP430 interrupt entry sequence
module interrupt_acceptor #(
    parameter logic [15:0] IVT_BASE  = 16'hFF80,
    parameter logic [5:0]  NMI_MIN   = 6'd61,
    parameter logic [5:0]  RESET_IDX = 6'd63
) (
    input  logic        MCLK,
    input  logic        RSTn,
    input  logic        req,
    input  logic [5:0]  IntAddr,
    input  logic        GIE,
    input  logic        instrBoundary,
    input  logic [15:0] PC,
    input  logic [15:0] SR,
    input  logic [15:0] SP,
    input  logic [15:0] memRdData,
    output logic        busy,
    output logic [15:0] memAddr,
    output logic [15:0] memWrData,
    output logic        memWrite,
    output logic        memRead,
    output logic [15:0] SPout,
    output logic        SPwrite,
    output logic [15:0] PCout,
    output logic        PCwrite,
    output logic [15:0] SRout,
    output logic        SRwrite,
    output logic        INTACK,
    output logic [5:0]  IntAddrAck
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PUSH_PC   = 3'd1,
        S_PUSH_SR   = 3'd2,
        S_FETCH_VEC = 3'd3,
        S_LOAD_PC   = 3'd4,
        S_ACK       = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  vec_idx_q, vec_idx_d;
    logic        holdoff_q, holdoff_d;
    logic        accept;
    logic [15:0] sp_dec;

    assign sp_dec = SP - 16'd2;
    assign accept = req && instrBoundary && !holdoff_q && (GIE || (IntAddr >= NMI_MIN));

    always_ff @(posedge MCLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= S_IDLE;
            vec_idx_q <= 6'd0;
            holdoff_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_idx_q <= vec_idx_d;
            holdoff_q <= holdoff_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_idx_d = vec_idx_q;
        holdoff_d = holdoff_q;
        case (state_q)
            S_IDLE: begin
                // holdoff lasts exactly one IDLE cycle so a request dropped on the ACK edge is not re-taken
                holdoff_d = 1'b0;
                if (accept) begin
                    vec_idx_d = IntAddr;
                    state_d   = (IntAddr == RESET_IDX) ? S_FETCH_VEC : S_PUSH_PC;
                end
            end
            S_PUSH_PC:   state_d = S_PUSH_SR;
            S_PUSH_SR:   state_d = S_FETCH_VEC;
            S_FETCH_VEC: state_d = S_LOAD_PC;
            S_LOAD_PC:   state_d = S_ACK;
            S_ACK: begin
                holdoff_d = 1'b1;
                state_d   = S_IDLE;
            end
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        memAddr    = 16'h0000;
        memWrData  = 16'h0000;
        memWrite   = 1'b0;
        memRead    = 1'b0;
        SPout      = 16'h0000;
        SPwrite    = 1'b0;
        PCout      = 16'h0000;
        PCwrite    = 1'b0;
        SRout      = 16'h0000;
        SRwrite    = 1'b0;
        INTACK     = 1'b0;
        IntAddrAck = 6'd0;
        case (state_q)
            S_PUSH_PC: begin
                memAddr   = sp_dec;
                memWrData = PC;
                memWrite  = 1'b1;
                SPout     = sp_dec;
                SPwrite   = 1'b1;
            end
            // the core has already taken the first SP decrement, so SP here is post-PC-push
            S_PUSH_SR: begin
                memAddr   = sp_dec;
                memWrData = SR;
                memWrite  = 1'b1;
                SPout     = sp_dec;
                SPwrite   = 1'b1;
            end
            S_FETCH_VEC: begin
                memAddr = IVT_BASE + {9'd0, vec_idx_q, 1'b0};
                memRead = 1'b1;
            end
            S_LOAD_PC: begin
                PCout   = memRdData;
                PCwrite = 1'b1;
                SRout   = (vec_idx_q == RESET_IDX) ? 16'h0000 : (SR & 16'h0040);
                SRwrite = 1'b1;
            end
            S_ACK: begin
                INTACK     = 1'b1;
                IntAddrAck = vec_idx_q;
            end
            default: ;
        endcase
    end

endmodule
